// File: rtl/stb_host_bridge_pkg.sv
// ---------------------------------------------------------------------------
// stb_host_bridge_pkg
// Shared types and constants for the host-facing bridge of the stream trace
// buffer. It provides:
//   - TRB_WIDTH, the buffer data word width
//   - control_t and status_t, the buffer control and status word layouts
//   - host_op_e, the host command opcodes
//   - HOST_ACK and HOST_ERR, the reply bytes
//   - bridge_state_e, the bridge FSM states
//   - numBytes(), the number of bytes needed to carry a word of a given width
// ---------------------------------------------------------------------------
package stb_host_bridge_pkg;

    localparam int unsigned TRB_WIDTH = 32;

    // Control word written by the host into the trace buffer
    typedef struct packed {
        logic       enable;
        logic       clear;
        logic [1:0] mode;
        logic [7:0] trigSel;
    } control_t;

    // Status word read back by the host from the trace buffer
    typedef struct packed {
        logic       full;
        logic       empty;
        logic [7:0] level;
    } status_t;

    // Host command opcodes; every other byte value is treated as an error
    typedef enum logic [7:0] {
        OP_WR_CTRL = 8'h01,
        OP_RD_STAT = 8'h02,
        OP_WR_DATA = 8'h03,
        OP_RD_DATA = 8'h04
    } host_op_e;

    localparam logic [7:0] HOST_ACK = 8'hAC;
    localparam logic [7:0] HOST_ERR = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_PAY,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_TX_REPLY,
        ST_TX_ERR
    } bridge_state_e;

    // Number of bytes that carry a word of the given width, i.e. ceil(width/8)
    function automatic int unsigned numBytes(input int unsigned width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/stb_timeout_counter.sv
// ---------------------------------------------------------------------------
// stb_timeout_counter
// Counts idle cycles while a command is in flight. expired_o is high in the
// cycle that would be the TIMEOUT_CYC-th consecutive enabled cycle without a
// clear. A clear in that same cycle suppresses expiry, so a handshake that
// lands on the last cycle still wins.
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   synchronous active-high reset
//   clear_i    in   restart the count (any handshake, or not counting)
//   enable_i   in   count this cycle
//   expired_o  out  idle limit reached this cycle
// ---------------------------------------------------------------------------
module stb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;

    // Idle-cycle counter. It saturates at LAST, although the bridge always
    // leaves the counted states as soon as expiry is flagged.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Expiry is reported in the last allowed idle cycle, unless it is cleared
    assign expired_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/stb_host_bridge.sv
// ---------------------------------------------------------------------------
// stb_host_bridge
// Parses a host byte stream into control writes, data writes, status reads
// and data reads on the trace buffer's ready/valid channels. Replies are
// serialized back as bytes, least-significant byte first.
// Ports:
//   CLK_I, RST_I                             clock, synchronous active-high reset
//   RX_VALID_I / RX_READY_O / RX_DATA_I      host bytes in
//   TX_VALID_O / TX_READY_I / TX_DATA_O      reply bytes out
//   CONTROL_VALID_O / CONTROL_READY_I / CONTROL_O   control word write
//   STATUS_VALID_I / STATUS_READY_O / STATUS_I      status word read
//   DATA_VALID_O / DATA_READY_I / DATA_O            data word write
//   DATA_VALID_I / DATA_READY_O / DATA_I            data word read
// ---------------------------------------------------------------------------
module stb_host_bridge
    import stb_host_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = TRB_WIDTH,
    parameter int unsigned CTRL_WIDTH  = $bits(control_t),
    parameter int unsigned STAT_WIDTH  = $bits(status_t),
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  RX_VALID_I,
    output logic                  RX_READY_O,
    input  logic [7:0]            RX_DATA_I,
    output logic                  TX_VALID_O,
    input  logic                  TX_READY_I,
    output logic [7:0]            TX_DATA_O,
    output logic                  CONTROL_VALID_O,
    input  logic                  CONTROL_READY_I,
    output logic [CTRL_WIDTH-1:0] CONTROL_O,
    input  logic                  STATUS_VALID_I,
    output logic                  STATUS_READY_O,
    input  logic [STAT_WIDTH-1:0] STATUS_I,
    output logic                  DATA_VALID_O,
    input  logic                  DATA_READY_I,
    output logic [DATA_WIDTH-1:0] DATA_O,
    input  logic                  DATA_VALID_I,
    output logic                  DATA_READY_O,
    input  logic [DATA_WIDTH-1:0] DATA_I
);

    localparam int unsigned MAX_DC = (DATA_WIDTH > CTRL_WIDTH) ? DATA_WIDTH : CTRL_WIDTH;
    localparam int unsigned MAX_W  = (MAX_DC > STAT_WIDTH) ? MAX_DC : STAT_WIDTH;
    localparam int unsigned MAX_N  = numBytes(MAX_W);
    localparam int unsigned SR_W   = MAX_N * 8;
    localparam int unsigned IDX_W  = $clog2(MAX_N) + 1;

    localparam logic [IDX_W-1:0] LEN_CTRL = IDX_W'(numBytes(CTRL_WIDTH));
    localparam logic [IDX_W-1:0] LEN_DATA = IDX_W'(numBytes(DATA_WIDTH));
    localparam logic [IDX_W-1:0] LEN_STAT = IDX_W'(numBytes(STAT_WIDTH));
    localparam logic [IDX_W-1:0] LEN_ONE  = IDX_W'(1);

    bridge_state_e    state_q, state_d;
    host_op_e         op_q, op_d;
    logic [IDX_W-1:0] byteIdx_q, byteIdx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [SR_W-1:0]  shiftReg_q, shiftReg_d;
    logic             outEn_q;

    logic anyHandshake;
    logic countEn;
    logic expired;

    // The state register already holds IDLE while reset is asserted. outEn_q
    // keeps RX_READY_O low until the first cycle after reset is released.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_WR_CTRL;
            byteIdx_q  <= '0;
            len_q      <= '0;
            shiftReg_q <= '0;
            outEn_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            byteIdx_q  <= byteIdx_d;
            len_q      <= len_d;
            shiftReg_q <= shiftReg_d;
            outEn_q    <= 1'b1;
        end
    end

    // Channel outputs depend only on registered state, so they stay stable
    // for the whole cycle. Data buses read 0 whenever their valid is low.
    always_comb begin
        RX_READY_O      = 1'b0;
        TX_VALID_O      = 1'b0;
        TX_DATA_O       = 8'h00;
        CONTROL_VALID_O = 1'b0;
        CONTROL_O       = '0;
        DATA_VALID_O    = 1'b0;
        DATA_O          = '0;
        STATUS_READY_O  = 1'b0;
        DATA_READY_O    = 1'b0;
        countEn         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                RX_READY_O = outEn_q;
            end
            ST_RX_PAY: begin
                RX_READY_O = 1'b1;
                countEn    = 1'b1;
            end
            ST_ISSUE: begin
                countEn = 1'b1;
                if (op_q == OP_WR_CTRL) begin
                    CONTROL_VALID_O = 1'b1;
                    CONTROL_O       = shiftReg_q[CTRL_WIDTH-1:0];
                end else begin
                    DATA_VALID_O = 1'b1;
                    DATA_O       = shiftReg_q[DATA_WIDTH-1:0];
                end
            end
            ST_WAIT_RD: begin
                countEn        = 1'b1;
                STATUS_READY_O = (op_q == OP_RD_STAT);
                DATA_READY_O   = (op_q == OP_RD_DATA);
            end
            ST_TX_REPLY: begin
                TX_VALID_O = 1'b1;
                TX_DATA_O  = shiftReg_q[7:0];
            end
            ST_TX_ERR: begin
                TX_VALID_O = 1'b1;
                TX_DATA_O  = HOST_ERR;
            end
            default: begin
                RX_READY_O = 1'b0;
            end
        endcase
    end

    // A handshake on any channel restarts the idle count
    assign anyHandshake = (RX_VALID_I && RX_READY_O) || (TX_VALID_O && TX_READY_I) ||
                          (CONTROL_VALID_O && CONTROL_READY_I) ||
                          (STATUS_VALID_I && STATUS_READY_O) ||
                          (DATA_VALID_O && DATA_READY_I) ||
                          (DATA_VALID_I && DATA_READY_O);

    stb_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) uTimeout (
        .clk_i     (CLK_I),
        .rst_i     (RST_I),
        .clear_i   (anyHandshake || !countEn),
        .enable_i  (countEn),
        .expired_o (expired)
    );

    // Next-state logic. The one shift register is filled byte by byte for
    // writes, is loaded with a whole word for reads or with the ACK byte,
    // and is shifted right one byte per accepted TX byte. The handshake
    // branches come before the expiry check, so a handshake in the expiry
    // cycle completes normally.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        byteIdx_d  = byteIdx_q;
        len_d      = len_q;
        shiftReg_d = shiftReg_q;
        case (state_q)
            ST_IDLE: begin
                if (RX_READY_O && RX_VALID_I) begin
                    op_d      = host_op_e'(RX_DATA_I);
                    byteIdx_d = '0;
                    case (RX_DATA_I)
                        OP_WR_CTRL: begin
                            len_d   = LEN_CTRL;
                            state_d = ST_RX_PAY;
                        end
                        OP_WR_DATA: begin
                            len_d   = LEN_DATA;
                            state_d = ST_RX_PAY;
                        end
                        OP_RD_STAT, OP_RD_DATA: begin
                            state_d = ST_WAIT_RD;
                        end
                        default: begin
                            state_d = ST_TX_ERR;
                        end
                    endcase
                end
            end
            ST_RX_PAY: begin
                if (RX_VALID_I) begin
                    for (int b = 0; b < int'(MAX_N); b++) begin
                        if (byteIdx_q == IDX_W'(b)) begin
                            shiftReg_d[b*8 +: 8] = RX_DATA_I;
                        end
                    end
                    if (byteIdx_q == len_q - 1'b1) begin
                        state_d = ST_ISSUE;
                    end else begin
                        byteIdx_d = byteIdx_q + 1'b1;
                    end
                end else if (expired) begin
                    state_d = ST_TX_ERR;
                end
            end
            ST_ISSUE: begin
                if ((CONTROL_VALID_O && CONTROL_READY_I) || (DATA_VALID_O && DATA_READY_I)) begin
                    shiftReg_d = SR_W'(HOST_ACK);
                    len_d      = LEN_ONE;
                    byteIdx_d  = '0;
                    state_d    = ST_TX_REPLY;
                end else if (expired) begin
                    state_d = ST_TX_ERR;
                end
            end
            ST_WAIT_RD: begin
                if (STATUS_READY_O && STATUS_VALID_I) begin
                    shiftReg_d                 = '0;
                    shiftReg_d[STAT_WIDTH-1:0] = STATUS_I;
                    len_d                      = LEN_STAT;
                    byteIdx_d                  = '0;
                    state_d                    = ST_TX_REPLY;
                end else if (DATA_READY_O && DATA_VALID_I) begin
                    shiftReg_d                 = '0;
                    shiftReg_d[DATA_WIDTH-1:0] = DATA_I;
                    len_d                      = LEN_DATA;
                    byteIdx_d                  = '0;
                    state_d                    = ST_TX_REPLY;
                end else if (expired) begin
                    state_d = ST_TX_ERR;
                end
            end
            ST_TX_REPLY: begin
                if (TX_READY_I) begin
                    shiftReg_d = shiftReg_q >> 8;
                    if (byteIdx_q == len_q - 1'b1) begin
                        state_d = ST_IDLE;
                    end else begin
                        byteIdx_d = byteIdx_q + 1'b1;
                    end
                end
            end
            ST_TX_ERR: begin
                if (TX_READY_I) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stb_host_bridge.sv
// ---------------------------------------------------------------------------
// tb_stb_host_bridge
// Directed bench for stb_host_bridge. Expected reply bytes and sink words are
// pushed into queues when a command is issued. A separate monitor pops and
// compares them whenever the DUT completes a handshake on that channel.
// ---------------------------------------------------------------------------
module tb_stb_host_bridge;

    localparam int DW = 32;
    localparam int CW = 12;
    localparam int SW = 10;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxValid = 1'b0;
    logic          rxReady;
    logic [7:0]    rxData = 8'h00;
    logic          txValid;
    logic          txReady = 1'b0;
    logic [7:0]    txData;
    logic          ctrlValid;
    logic          ctrlReady = 1'b0;
    logic [CW-1:0] ctrlWord;
    logic          statValid = 1'b0;
    logic          statReady;
    logic [SW-1:0] statWord = '0;
    logic          dataValidOut;
    logic          dataReadyIn = 1'b0;
    logic [DW-1:0] dataOut;
    logic          dataValidIn = 1'b0;
    logic          dataReadyOut;
    logic [DW-1:0] dataIn = '0;

    logic [7:0]  expTx[$];
    logic [31:0] expCtrl[$];
    logic [31:0] expData[$];

    int testsRun = 0;
    int failCount = 0;
    int txMode = 0;
    int dataValidCycles = 0;

    always #5 clk = ~clk;

    stb_host_bridge #(
        .DATA_WIDTH  (DW),
        .CTRL_WIDTH  (CW),
        .STAT_WIDTH  (SW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK_I           (clk),
        .RST_I           (rst),
        .RX_VALID_I      (rxValid),
        .RX_READY_O      (rxReady),
        .RX_DATA_I       (rxData),
        .TX_VALID_O      (txValid),
        .TX_READY_I      (txReady),
        .TX_DATA_O       (txData),
        .CONTROL_VALID_O (ctrlValid),
        .CONTROL_READY_I (ctrlReady),
        .CONTROL_O       (ctrlWord),
        .STATUS_VALID_I  (statValid),
        .STATUS_READY_O  (statReady),
        .STATUS_I        (statWord),
        .DATA_VALID_O    (dataValidOut),
        .DATA_READY_I    (dataReadyIn),
        .DATA_O          (dataOut),
        .DATA_VALID_I    (dataValidIn),
        .DATA_READY_O    (dataReadyOut),
        .DATA_I          (dataIn)
    );

    // Single comparison point: every check counts here
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one cycle and land 1 time unit after the edge. txMode sets the
    // reply-side ready pattern: 0 always ready, 1 toggling, 2 held low.
    task automatic tick();
        @(posedge clk);
        #1;
        case (txMode)
            0:       txReady = 1'b1;
            1:       txReady = ~txReady;
            default: txReady = 1'b0;
        endcase
    endtask

    // Present one host byte and hold it until the bridge accepts it
    task automatic applyStimulus(input logic [7:0] b);
        int   n;
        logic hs;
        n = 0;
        rxValid = 1'b1;
        rxData  = b;
        do begin
            hs = rxReady;
            tick();
            n++;
        end while (!hs && n < 60);
        rxValid = 1'b0;
        if (!hs) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL rxAccept: byte 0x%0h not accepted within %0d cycles", b, n);
        end
    endtask

    // Wait until every expected reply byte is consumed and the bridge is idle
    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (!(expTx.size() == 0 && rxReady) && n < 200) begin
            tick();
            n++;
        end
        checkOutput({name, "_drained"}, 32'(n < 200), 32'd1);
    endtask

    // Cycles from now until TX_VALID_O is seen
    task automatic measureTxLatency(output int n);
        n = 0;
        while (!txValid && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Hold reset, check the reset values, then release it and check that
    // RX_READY_O rises exactly one cycle after the release
    task automatic pulseReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        expTx.delete();
        expCtrl.delete();
        expData.delete();
        checkOutput("rst_rxReady", 32'(rxReady), 32'd0);
        checkOutput("rst_txValid", 32'(txValid), 32'd0);
        checkOutput("rst_ctrlValid", 32'(ctrlValid), 32'd0);
        checkOutput("rst_dataValid", 32'(dataValidOut), 32'd0);
        checkOutput("rst_statReady", 32'(statReady), 32'd0);
        checkOutput("rst_dataReady", 32'(dataReadyOut), 32'd0);
        checkOutput("rst_buses", {txData, 12'(ctrlWord), 12'(dataOut != 0)}, 32'd0);
        rst = 1'b0;
        checkOutput("rst_rxReadyHeld", 32'(rxReady), 32'd0);
        tick();
        checkOutput("rst_rxReadyRise", 32'(rxReady), 32'd1);
    endtask

    // Monitor: pops and compares at each handshake, seen at the negative
    // edge before the rising edge that completes it. It also checks that
    // payloads stay stable while valid is held without ready.
    initial begin : monitor
        logic        txHold, ctrlHold, dataHold;
        logic [7:0]  prevTx;
        logic [31:0] prevCtrl, prevData;
        txHold = 1'b0;
        ctrlHold = 1'b0;
        dataHold = 1'b0;
        prevTx = 8'h00;
        prevCtrl = '0;
        prevData = '0;
        forever begin
            @(negedge clk);
            if (dataValidOut) dataValidCycles++;
            if (rst) begin
                txHold = 1'b0;
                ctrlHold = 1'b0;
                dataHold = 1'b0;
            end else begin
                if (txValid) begin
                    if (txHold) checkOutput("txStable", 32'(txData), 32'(prevTx));
                    if (txReady) begin
                        if (expTx.size() == 0) begin
                            testsRun++;
                            failCount++;
                            $display("[TB] FAIL txUnexpected: got byte 0x%0h, expected none", txData);
                        end else begin
                            checkOutput("txByte", 32'(txData), 32'(expTx.pop_front()));
                        end
                    end
                end
                if (ctrlValid) begin
                    if (ctrlHold) checkOutput("ctrlStable", 32'(ctrlWord), prevCtrl);
                    if (ctrlReady) begin
                        if (expCtrl.size() == 0) begin
                            testsRun++;
                            failCount++;
                            $display("[TB] FAIL ctrlUnexpected: got 0x%0h, expected none", ctrlWord);
                        end else begin
                            checkOutput("ctrlWord", 32'(ctrlWord), expCtrl.pop_front());
                        end
                    end
                end
                if (dataValidOut) begin
                    if (dataHold) checkOutput("dataStable", dataOut, prevData);
                    if (dataReadyIn) begin
                        if (expData.size() == 0) begin
                            testsRun++;
                            failCount++;
                            $display("[TB] FAIL dataUnexpected: got 0x%0h, expected none", dataOut);
                        end else begin
                            checkOutput("dataWord", dataOut, expData.pop_front());
                        end
                    end
                end
                txHold   = txValid && !txReady;
                prevTx   = txData;
                ctrlHold = ctrlValid && !ctrlReady;
                prevCtrl = 32'(ctrlWord);
                dataHold = dataValidOut && !dataReadyIn;
                prevData = dataOut;
            end
        end
    end

    // Global time limit so the run always ends
    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed command sequence
    initial begin : stimulus
        int lat;
        pulseReset(3);

        // Control write; the word is held while the sink is not ready
        expCtrl.push_back(32'h234);
        expTx.push_back(8'hAC);
        applyStimulus(8'h01);
        applyStimulus(8'h34);
        applyStimulus(8'hF2);
        checkOutput("ctrlValidLatency", 32'(ctrlValid), 32'd1);
        repeat (4) tick();
        ctrlReady = 1'b1;
        waitDrain("wrCtrl");
        ctrlReady = 1'b0;

        // Data write with the sink stalled for 5 cycles
        expData.push_back(32'hDEADBEEF);
        expTx.push_back(8'hAC);
        applyStimulus(8'h03);
        applyStimulus(8'hEF);
        applyStimulus(8'hBE);
        applyStimulus(8'hAD);
        applyStimulus(8'hDE);
        checkOutput("dataValidLatency", 32'(dataValidOut), 32'd1);
        repeat (5) tick();
        dataReadyIn = 1'b1;
        waitDrain("wrData");
        dataReadyIn = 1'b0;

        // Data read; source valid after 3 cycles, reply side toggling ready
        txMode = 1;
        expTx.push_back(8'h04);
        expTx.push_back(8'h03);
        expTx.push_back(8'h02);
        expTx.push_back(8'h01);
        applyStimulus(8'h04);
        checkOutput("rdReadyLatency", 32'(dataReadyOut), 32'd1);
        repeat (3) tick();
        dataValidIn = 1'b1;
        dataIn = 32'h01020304;
        lat = 0;
        while (!dataReadyOut && lat < 40) begin
            tick();
            lat++;
        end
        tick();
        dataValidIn = 1'b0;
        waitDrain("rdData");
        txMode = 0;

        // Status read, bad opcode, then a normal status read again
        statValid = 1'b1;
        statWord = 10'h3A5;
        expTx.push_back(8'hA5);
        expTx.push_back(8'h03);
        applyStimulus(8'h02);
        waitDrain("rdStat");
        statValid = 1'b0;
        expTx.push_back(8'hEE);
        applyStimulus(8'h7F);
        waitDrain("badOpcode");
        statValid = 1'b1;
        statWord = 10'h15A;
        expTx.push_back(8'h5A);
        expTx.push_back(8'h01);
        applyStimulus(8'h02);
        waitDrain("rdStatAfterErr");
        statValid = 1'b0;

        // Partial data write, then silence: error after the idle limit
        dataValidCycles = 0;
        expTx.push_back(8'hEE);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        measureTxLatency(lat);
        checkOutput("wrTimeoutLatency", 32'(lat), 32'(TO));
        waitDrain("wrTimeout");
        checkOutput("wrTimeoutNoDataValid", 32'(dataValidCycles), 32'd0);

        // Status read with no status valid: error after the idle limit
        expTx.push_back(8'hEE);
        applyStimulus(8'h02);
        measureTxLatency(lat);
        checkOutput("rdTimeoutLatency", 32'(lat), 32'(TO));
        waitDrain("rdTimeout");

        // Sink ready arrives exactly in the expiry cycle: the write still completes
        expCtrl.push_back(32'hBCD);
        expTx.push_back(8'hAC);
        applyStimulus(8'h01);
        applyStimulus(8'hCD);
        applyStimulus(8'hAB);
        repeat (TO - 1) tick();
        ctrlReady = 1'b1;
        waitDrain("hsAtExpiry");
        ctrlReady = 1'b0;

        // Reset in the middle of a data write payload
        dataValidCycles = 0;
        applyStimulus(8'h03);
        applyStimulus(8'hAA);
        pulseReset(2);
        repeat (TO + 4) tick();
        checkOutput("rstRxPayNoTx", 32'(txValid), 32'd0);
        checkOutput("rstRxPayNoDataValid", 32'(dataValidCycles), 32'd0);
        statValid = 1'b1;
        statWord = 10'h3A5;
        expTx.push_back(8'hA5);
        expTx.push_back(8'h03);
        applyStimulus(8'h02);
        waitDrain("rdStatAfterReset");
        statValid = 1'b0;

        // Reset while the reply is being stalled by the host
        txMode = 2;
        dataValidIn = 1'b1;
        dataIn = 32'hCAFEF00D;
        applyStimulus(8'h04);
        measureTxLatency(lat);
        checkOutput("rdReplyPending", 32'(txValid), 32'd1);
        dataValidIn = 1'b0;
        pulseReset(2);
        txMode = 0;
        repeat (8) tick();
        checkOutput("rstTxReplyNoTx", 32'(txValid), 32'd0);

        checkOutput("expTxEmpty", 32'(expTx.size()), 32'd0);
        checkOutput("expCtrlEmpty", 32'(expCtrl.size()), 32'd0);
        checkOutput("expDataEmpty", 32'(expData.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
